imem_sync: RTL and testbench

Parametrised, loadable instruction memory that replaces the fixed combinational program ROM in the fetch stage.
- Contents are written at runtime through a program-load port.
- Reads are synchronous: one cycle of latency, with a valid/stall/flush handshake toward decode.
- After reset the block clears the whole array to NOP via an internal init sequencer before accepting traffic.
- Out-of-range fetches return NOP and raise a fault flag.

---
 rtl/imem_sync_pkg.sv | 22 ++
 rtl/imem_ram.sv | 29 ++
 rtl/imem_sync.sv | 129 ++++++++++++
 tb/tb_imem_sync.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_sync_pkg.sv
// Shared constants for the loadable instruction memory.
// Latency: n/a (constants and a width helper only).
// Backpressure: n/a.
package imem_sync_pkg;

    // Default PC / load address width and instruction width.
    localparam int INST_ADDR_LENGTH = 16;
    localparam int INST_BUS_LENGTH  = 16;

    // Encoding of the no-operation instruction used for fill and faults.
    localparam logic [15:0] INST_NOP = 16'h0000;

    // Sequencer states: clearing the array, then serving traffic.
    localparam logic [0:0] IMEM_INIT  = 1'b0;
    localparam logic [0:0] IMEM_READY = 1'b1;

    // Index width for an array of 'depth' words; never narrower than one bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-clock instruction storage: one write port, one address-indexed read.
// Latency: write lands at the clock edge; read data follows rd_addr combinationally.
// Backpressure: none; the owner decides when to write and when to sample.
module imem_ram #(
    parameter int DEPTH  = 64,
    parameter int INST_W = 16,
    parameter int IDX_W  = 6
) (
    input  logic              clk_i,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [INST_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [INST_W-1:0] rd_data
);

    // No reset on the array so it maps onto RAM; the owner clears it after reset.
    logic [INST_W-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/imem_sync.sv
// Loadable instruction memory for the fetch stage, cleared to NOP after reset.
// Latency: fetch at edge N is visible in cycle N+1; back-to-back fetches at full rate.
// Backpressure: stall_i holds the output, flush_i kills it; nothing accepted until ready_o.
module imem_sync
    import imem_sync_pkg::*;
#(
    parameter int                ADDR_W   = INST_ADDR_LENGTH,
    parameter int                INST_W   = INST_BUS_LENGTH,
    parameter int                DEPTH    = 64,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(INST_NOP)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    output logic              ready_o,
    input  logic              fetch_req_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] PC_i,
    output logic [INST_W-1:0] inst_o,
    output logic              inst_valid_o,
    output logic              addr_fault_o,
    input  logic              load_en_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [INST_W-1:0] load_data_i,
    output logic              load_err_o
);

    localparam int IDX_W = idx_width(DEPTH);

    // Range checks use the full address width so out-of-range PCs never alias.
    localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

    logic [0:0]        state;
    logic [IDX_W-1:0]  clr_cnt;
    logic              is_ready;
    logic              load_in_range;
    logic              pc_in_range;
    logic              load_wr;
    logic              bypass_hit;
    logic              ram_we;
    logic [IDX_W-1:0]  ram_waddr;
    logic [INST_W-1:0] ram_wdata;
    logic [INST_W-1:0] ram_rdata;
    logic [INST_W-1:0] fetch_data;

    assign is_ready      = (state == IMEM_READY);
    assign load_in_range = ({1'b0, load_addr_i} < DEPTH_EXT);
    assign pc_in_range   = ({1'b0, PC_i} < DEPTH_EXT);
    assign load_wr       = is_ready && load_en_i && load_in_range;

    // A load to the address being fetched in the same cycle wins (write-first).
    assign bypass_hit = load_wr && (load_addr_i == PC_i);
    assign fetch_data = bypass_hit ? load_data_i : ram_rdata;

    // Write port is owned by the clear sequencer during init, by the load port afterwards.
    always_comb begin
        ram_we    = load_wr;
        ram_waddr = load_addr_i[IDX_W-1:0];
        ram_wdata = load_data_i;
        if (!is_ready) begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt;
            ram_wdata = NOP_INST;
        end
    end

    imem_ram #(
        .DEPTH  (DEPTH),
        .INST_W (INST_W),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk_i   (clk_i),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .rd_addr (PC_i[IDX_W-1:0]),
        .rd_data (ram_rdata)
    );

    // Init sequencer: one word cleared per cycle, READY after the last word is written.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= IMEM_INIT;
            clr_cnt <= '0;
        end else if (!is_ready) begin
            if (clr_cnt == LAST_IDX) begin
                state <= IMEM_READY;
            end else begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    // Output register: flush over stall over fetch; the data word holds unless a fetch lands.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            inst_o       <= NOP_INST;
            inst_valid_o <= 1'b0;
            addr_fault_o <= 1'b0;
        end else if (is_ready) begin
            if (flush_i) begin
                inst_valid_o <= 1'b0;
                addr_fault_o <= 1'b0;
            end else if (stall_i) begin
                inst_valid_o <= inst_valid_o;
            end else if (fetch_req_i) begin
                inst_o       <= pc_in_range ? fetch_data : NOP_INST;
                inst_valid_o <= 1'b1;
                addr_fault_o <= !pc_in_range;
            end else begin
                inst_valid_o <= 1'b0;
                addr_fault_o <= 1'b0;
            end
        end
    end

    // Dropped-load indication, a single-cycle pulse after the offending strobe.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            load_err_o <= 1'b0;
        end else begin
            load_err_o <= is_ready && load_en_i && !load_in_range;
        end
    end

    assign ready_o = is_ready;

endmodule

// File: tb/tb_imem_sync.sv
// Directed self-checking bench for imem_sync with DEPTH=64.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
// Each scenario task does its own comparisons and bumps the shared counters.
module tb_imem_sync;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        ready_o;
    logic        fetch_req_i;
    logic        stall_i;
    logic        flush_i;
    logic [15:0] PC_i;
    logic [15:0] inst_o;
    logic        inst_valid_o;
    logic        addr_fault_o;
    logic        load_en_i;
    logic [15:0] load_addr_i;
    logic [15:0] load_data_i;
    logic        load_err_o;

    int compared   = 0;
    int mismatched = 0;

    imem_sync #(
        .ADDR_W   (16),
        .INST_W   (16),
        .DEPTH    (64),
        .NOP_INST (16'h0000)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .ready_o      (ready_o),
        .fetch_req_i  (fetch_req_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .PC_i         (PC_i),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .addr_fault_o (addr_fault_o),
        .load_en_i    (load_en_i),
        .load_addr_i  (load_addr_i),
        .load_data_i  (load_data_i),
        .load_err_o   (load_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_req_i = 1'b0;
        stall_i     = 1'b0;
        flush_i     = 1'b0;
        PC_i        = 16'd0;
        load_en_i   = 1'b0;
        load_addr_i = 16'd0;
        load_data_i = 16'd0;
    endtask

    // Reset values, then 64 INIT cycles with a fetch held the whole time.
    task automatic test_reset();
        rst_n_i = 1'b0;
        idle_inputs();
        fetch_req_i = 1'b1;
        PC_i        = 16'd5;
        tick();
        tick();
        compared++;
        if (ready_o !== 1'b0 || inst_valid_o !== 1'b0 || addr_fault_o !== 1'b0 ||
            load_err_o !== 1'b0 || inst_o !== 16'h0000) begin
            mismatched++;
            $display("FAIL reset_values: ready=%b valid=%b fault=%b lerr=%b inst=%h, want 0 0 0 0 0000",
                     ready_o, inst_valid_o, addr_fault_o, load_err_o, inst_o);
        end
        rst_n_i = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            tick();
            compared++;
            if (ready_o !== (i == 64)) begin
                mismatched++;
                $display("FAIL init_ready cycle %0d: got %b want %b", i, ready_o, (i == 64));
            end
            compared++;
            if (inst_valid_o !== 1'b0) begin
                mismatched++;
                $display("FAIL init_valid cycle %0d: got %b want 0", i, inst_valid_o);
            end
        end
        tick();
        compared++;
        if (inst_valid_o !== 1'b1 || inst_o !== 16'h0000 || addr_fault_o !== 1'b0) begin
            mismatched++;
            $display("FAIL first_fetch: valid=%b inst=%h fault=%b, want 1 0000 0",
                     inst_valid_o, inst_o, addr_fault_o);
        end
    endtask

    // Load a word, then fetch it back.
    task automatic test_load_fetch();
        idle_inputs();
        load_en_i   = 1'b1;
        load_addr_i = 16'd5;
        load_data_i = 16'h8805;
        tick();
        compared++;
        if (inst_valid_o !== 1'b0 || load_err_o !== 1'b0) begin
            mismatched++;
            $display("FAIL load_cycle: valid=%b lerr=%b, want 0 0", inst_valid_o, load_err_o);
        end
        idle_inputs();
        fetch_req_i = 1'b1;
        PC_i        = 16'd5;
        tick();
        compared++;
        if (inst_o !== 16'h8805 || inst_valid_o !== 1'b1 || addr_fault_o !== 1'b0) begin
            mismatched++;
            $display("FAIL fetch_pc5: inst=%h valid=%b fault=%b, want 8805 1 0",
                     inst_o, inst_valid_o, addr_fault_o);
        end
    endtask

    // Same-cycle load and fetch of PC 7 returns the new data, then it persists.
    task automatic test_bypass();
        idle_inputs();
        fetch_req_i = 1'b1;
        PC_i        = 16'd7;
        load_en_i   = 1'b1;
        load_addr_i = 16'd7;
        load_data_i = 16'h0A40;
        tick();
        compared++;
        if (inst_o !== 16'h0A40 || inst_valid_o !== 1'b1) begin
            mismatched++;
            $display("FAIL bypass_pc7: inst=%h valid=%b, want 0a40 1", inst_o, inst_valid_o);
        end
        idle_inputs();
        fetch_req_i = 1'b1;
        PC_i        = 16'd7;
        tick();
        compared++;
        if (inst_o !== 16'h0A40) begin
            mismatched++;
            $display("FAIL refetch_pc7: inst=%h want 0a40", inst_o);
        end
    endtask

    // Consecutive fetches of different words, one per cycle with no bubble.
    task automatic test_back_to_back();
        logic [15:0] pcs [3];
        logic [15:0] exp [3];
        pcs[0] = 16'd5; exp[0] = 16'h8805;
        pcs[1] = 16'd7; exp[1] = 16'h0A40;
        pcs[2] = 16'd3; exp[2] = 16'h0000;
        idle_inputs();
        fetch_req_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            PC_i = pcs[i];
            tick();
            compared++;
            if (inst_o !== exp[i] || inst_valid_o !== 1'b1) begin
                mismatched++;
                $display("FAIL b2b_%0d: inst=%h valid=%b, want %h 1", i, inst_o, inst_valid_o, exp[i]);
            end
        end
    endtask

    // Stall holds the output (a load meanwhile does not disturb it); flush beats stall.
    task automatic test_stall_flush();
        idle_inputs();
        fetch_req_i = 1'b1;
        PC_i        = 16'd5;
        tick();
        stall_i = 1'b1;
        PC_i    = 16'd6;
        for (int i = 0; i < 3; i++) begin
            load_en_i   = (i == 1);
            load_addr_i = 16'd9;
            load_data_i = 16'h1234;
            tick();
            compared++;
            if (inst_o !== 16'h8805 || inst_valid_o !== 1'b1 || addr_fault_o !== 1'b0) begin
                mismatched++;
                $display("FAIL stall_hold_%0d: inst=%h valid=%b fault=%b, want 8805 1 0",
                         i, inst_o, inst_valid_o, addr_fault_o);
            end
        end
        load_en_i = 1'b0;
        flush_i   = 1'b1;
        tick();
        compared++;
        if (inst_valid_o !== 1'b0 || addr_fault_o !== 1'b0 || inst_o !== 16'h8805) begin
            mismatched++;
            $display("FAIL flush_over_stall: valid=%b fault=%b inst=%h, want 0 0 8805",
                     inst_valid_o, addr_fault_o, inst_o);
        end
        idle_inputs();
        fetch_req_i = 1'b1;
        PC_i        = 16'd9;
        tick();
        compared++;
        if (inst_o !== 16'h1234 || inst_valid_o !== 1'b1) begin
            mismatched++;
            $display("FAIL load_during_stall: inst=%h valid=%b, want 1234 1", inst_o, inst_valid_o);
        end
    endtask

    // Out-of-range fetch and load behaviour, including an address that would alias.
    task automatic test_out_of_range();
        idle_inputs();
        fetch_req_i = 1'b1;
        PC_i        = 16'd64;
        tick();
        compared++;
        if (inst_o !== 16'h0000 || inst_valid_o !== 1'b1 || addr_fault_o !== 1'b1) begin
            mismatched++;
            $display("FAIL fetch_pc64: inst=%h valid=%b fault=%b, want 0000 1 1",
                     inst_o, inst_valid_o, addr_fault_o);
        end
        PC_i = 16'd69;
        tick();
        compared++;
        if (inst_o !== 16'h0000 || addr_fault_o !== 1'b1) begin
            mismatched++;
            $display("FAIL fetch_pc69_noalias: inst=%h fault=%b, want 0000 1", inst_o, addr_fault_o);
        end
        idle_inputs();
        load_en_i   = 1'b1;
        load_addr_i = 16'd70;
        load_data_i = 16'hFFFF;
        tick();
        compared++;
        if (load_err_o !== 1'b1 || inst_valid_o !== 1'b0 || addr_fault_o !== 1'b0) begin
            mismatched++;
            $display("FAIL load_err_pulse: lerr=%b valid=%b fault=%b, want 1 0 0",
                     load_err_o, inst_valid_o, addr_fault_o);
        end
        idle_inputs();
        tick();
        compared++;
        if (load_err_o !== 1'b0) begin
            mismatched++;
            $display("FAIL load_err_single: lerr=%b want 0", load_err_o);
        end
        fetch_req_i = 1'b1;
        PC_i        = 16'd6;
        tick();
        compared++;
        if (inst_o !== 16'h0000 || addr_fault_o !== 1'b0) begin
            mismatched++;
            $display("FAIL mem6_unchanged: inst=%h fault=%b, want 0000 0", inst_o, addr_fault_o);
        end
    endtask

    // Async reset mid-fetch and mid-init, then a full re-clear of the array.
    task automatic test_async_reset();
        idle_inputs();
        fetch_req_i = 1'b1;
        PC_i        = 16'd5;
        tick();
        #2;
        rst_n_i = 1'b0;
        #1;
        compared++;
        if (inst_o !== 16'h0000 || inst_valid_o !== 1'b0 || ready_o !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid_fetch: inst=%h valid=%b ready=%b, want 0000 0 0",
                     inst_o, inst_valid_o, ready_o);
        end
        tick();
        rst_n_i = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        #2;
        rst_n_i = 1'b0;
        #1;
        compared++;
        if (ready_o !== 1'b0 || inst_valid_o !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid_init: ready=%b valid=%b, want 0 0", ready_o, inst_valid_o);
        end
        tick();
        rst_n_i = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (i == 63 || i == 64) begin
                compared++;
                if (ready_o !== (i == 64)) begin
                    mismatched++;
                    $display("FAIL reinit_ready cycle %0d: got %b want %b", i, ready_o, (i == 64));
                end
            end
        end
        tick();
        compared++;
        if (inst_o !== 16'h0000 || inst_valid_o !== 1'b1) begin
            mismatched++;
            $display("FAIL mem5_cleared: inst=%h valid=%b, want 0000 1", inst_o, inst_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_load_fetch();
        test_bypass();
        test_back_to_back();
        test_stall_flush();
        test_out_of_range();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
